// File: rtl/bus_out_arbiter.sv
// bus_out_arbiter: round-robin one-hot bus source select with turnaround.
// Optional hold-limit revoke enabled by defining ARB_TIMEOUT_EN.
module bus_out_arbiter #(
  parameter int N        = 24,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IW = $clog2(N);
  localparam logic [IW:0] NW = (IW+1)'(N);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;

  state_t state, state_n;

  logic [N-1:0]  grant_n;
  logic [IW-1:0] gid_n;
  logic          busy_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [IW-1:0] win;
  logic          found;
  logic [IW:0]   win_inc;

  // An out-of-range MAX_HOLD shows up as this block in the hierarchy.
  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_max_hold_out_of_range
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD - 1);

  logic [HW-1:0] hold_cnt, hold_n;
  logic          to_q, to_n;
  logic          others;

  assign others  = |(req & ~grant);
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  // Round-robin search: first set request at or above ptr, wrapping.
  always_comb begin
    logic [IW:0] sum;
    logic [IW-1:0] idx;
    win   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= NW) begin
        sum = sum - NW;
      end
      idx = sum[IW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Pointer value after the winner, wrapping N-1 back to 0.
  always_comb begin
    win_inc = {1'b0, win} + (IW+1)'(1);
    if (win_inc == NW) begin
      win_inc = '0;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_n = state;
    grant_n = grant;
    gid_n   = grant_id;
    busy_n  = busy;
    ptr_n   = ptr;
`ifdef ARB_TIMEOUT_EN
    hold_n  = hold_cnt;
    to_n    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          grant_n = {{(N-1){1'b0}}, 1'b1} << win;
          gid_n   = win;
          busy_n  = 1'b1;
          ptr_n   = win_inc[IW-1:0];
`ifdef ARB_TIMEOUT_EN
          hold_n  = '0;
`endif
        end
      end
      GRANT: begin
        if (!req[grant_id]) begin
          state_n = TURN;
          grant_n = '0;
          busy_n  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        end else if (hold_cnt == HMAX && others) begin
          state_n = TURN;
          grant_n = '0;
          busy_n  = 1'b0;
          to_n    = 1'b1;
        end else if (hold_cnt != HMAX) begin
          hold_n  = hold_cnt + HW'(1);
`endif
        end
      end
      TURN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers; clear drops any grant at once.
  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= '0;
      to_q     <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      grant_id <= gid_n;
      busy     <= busy_n;
      ptr      <= ptr_n;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= hold_n;
      to_q     <= to_n;
`endif
    end
  end

  // Grant is never more than one-hot and busy mirrors it.
  always @(posedge clock) begin
    if (!clear) begin
      assert ($onehot0(grant));
      assert (busy == (|grant));
    end
  end

endmodule
